ex_alu_share_ctrl: RTL and testbench

//  Round-robin scheduler that shares one single-cycle bit-op/SUB/SLT ALU (AND, OR, XOR, SUB, signed/unsigned SLT) between NREQ issue requesters.

---
 rtl/ex_alu_share_ctrl_pkg.sv | 39 +++
 rtl/ex_alu_share_ctrl_if.sv | 53 +++++
 rtl/ex_alu_share_ctrl_rr_arbiter.sv | 49 ++++
 rtl/ex_alu_share_ctrl.sv | 115 +++++++++++
 tb/tb_ex_alu_share_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_alu_share_ctrl_pkg.sv
// ex_alu_share_ctrl_pkg
//   Shared types for the Execute-stage ALU sharing controller: the one-hot
//   bit-op enable vector, the canonical default-width request record, and
//   a one-hot legality helper.
//   No ports (package).
package ex_alu_share_ctrl_pkg;

  localparam int BITOP_W  = 5;
  localparam int CPU_XLEN = 32;
  localparam int EX_TAG_W = 4;

  typedef logic [CPU_XLEN-1:0] CpuType;

  // Declared MSB first, so band lands on bit 0 and slt on bit 4.
  typedef struct packed {
    logic slt;
    logic sub;
    logic bxor;
    logic bor;
    logic band;
  } BitOpEn_t;

  typedef struct packed {
    BitOpEn_t              op;
    CpuType                s1;
    logic                  s1sign;
    CpuType                s2;
    logic                  s2sign;
    logic [EX_TAG_W-1:0]   tag;
  } ExShareReq_t;

  // A request is legal only when exactly one ALU function is selected.
  function automatic logic bitop_is_onehot(input BitOpEn_t op);
    logic [BITOP_W-1:0] v;
    v = op;
    return $onehot(v);
  endfunction

endpackage

// File: rtl/ex_alu_share_ctrl_if.sv
// ex_alu_share_ctrl_if
//   Bundles the requester bus, the shared-ALU bus and the response bus of
//   ex_alu_share_ctrl.
//   master : controller view (requests/ALU result/consumer ready in,
//            grants/ALU operands/response out)
//   slave  : environment view (the mirror of master)
interface ex_alu_share_ctrl_if
  import ex_alu_share_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2,
  parameter int TAGW = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                iReqValid;
  logic [NREQ-1:0]                oReqReady;
  logic [NREQ-1:0][BITOP_W-1:0]   iReqOp;
  logic [NREQ-1:0][XLEN-1:0]      iReqS1;
  logic [NREQ-1:0][XLEN-1:0]      iReqS2;
  logic [NREQ-1:0]                iReqS1Sign;
  logic [NREQ-1:0]                iReqS2Sign;
  logic [NREQ-1:0][TAGW-1:0]      iReqTag;

  logic [BITOP_W-1:0]             oAluOp;
  logic [XLEN-1:0]                oAluS1;
  logic [XLEN-1:0]                oAluS2;
  logic                           oAluS1Sign;
  logic                           oAluS2Sign;
  logic [XLEN-1:0]                iAluResult;

  logic                           oRspValid;
  logic                           iRspReady;
  logic [XLEN-1:0]                oRspResult;
  logic [IDW-1:0]                 oRspId;
  logic [TAGW-1:0]                oRspTag;
  logic                           oRspBadOp;

  modport master (
    input  iReqValid, iReqOp, iReqS1, iReqS2, iReqS1Sign, iReqS2Sign, iReqTag,
    input  iAluResult, iRspReady,
    output oReqReady, oAluOp, oAluS1, oAluS2, oAluS1Sign, oAluS2Sign,
    output oRspValid, oRspResult, oRspId, oRspTag, oRspBadOp
  );

  modport slave (
    output iReqValid, iReqOp, iReqS1, iReqS2, iReqS1Sign, iReqS2Sign, iReqTag,
    output iAluResult, iRspReady,
    input  oReqReady, oAluOp, oAluS1, oAluS2, oAluS1Sign, oAluS2Sign,
    input  oRspValid, oRspResult, oRspId, oRspTag, oRspBadOp
  );

endinterface

// File: rtl/ex_alu_share_ctrl_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter: grants the first requester at or after the
//   pointer (wrapping), and moves the pointer past the winner on a grant.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   req[N]     : request vector
//   en         : grants allowed this cycle
//   gnt[N]     : one-hot grant (combinational)
//   gnt_idx    : index of the granted requester
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  // Scan offsets 0..N-1 from the pointer; the first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (en && !found && req[i] && (i == ((int'(ptr) + k) % N))) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IW'(i);
        end
      end
    end
  end

  // A grant is always consumed, so the pointer moves on every grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/ex_alu_share_ctrl.sv
// ex_alu_share_ctrl
//   Shares one single-cycle AND/OR/XOR/SUB/SLT ALU between NREQ issue
//   requesters. A round-robin grant steers the winner's op and operands to
//   the ALU combinationally; the ALU result, requester index and tag are
//   captured in a one-entry output stage with valid/ready back-pressure.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ex_alu_share_ctrl_if.master
//     iReqValid/oReqReady/iReqOp/iReqS1/iReqS2/iReqS1Sign/iReqS2Sign/iReqTag
//                : requester side
//     oAluOp/oAluS1/oAluS2/oAluS1Sign/oAluS2Sign/iAluResult : shared ALU
//     oRspValid/iRspReady/oRspResult/oRspId/oRspTag/oRspBadOp : response
module ex_alu_share_ctrl
  import ex_alu_share_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2,
  parameter int TAGW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ex_alu_share_ctrl_if.master bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    BitOpEn_t        op;
    logic [XLEN-1:0] s1;
    logic            s1sign;
    logic [XLEN-1:0] s2;
    logic            s2sign;
    logic [TAGW-1:0] tag;
  } req_t;

  logic            free_p0;
  logic            arb_en_p0;
  logic [NREQ-1:0] gnt_p0;
  logic [IDW-1:0]  gnt_idx_p0;
  logic            accept_p0;
  req_t            sel_p0;
  logic            bad_op_p0;

  logic            vld_p1;
  logic [XLEN-1:0] rsp_result_p1;
  logic [IDW-1:0]  rsp_id_p1;
  logic [TAGW-1:0] rsp_tag_p1;
  logic            rsp_bad_p1;

  // ---- p0: arbitration and operand steering ----
  // The output slot can take a new result when empty or draining this cycle.
  assign free_p0   = !vld_p1 || bus.iRspReady;
  assign arb_en_p0 = free_p0 && rst_n;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.iReqValid),
    .en      (arb_en_p0),
    .gnt     (gnt_p0),
    .gnt_idx (gnt_idx_p0)
  );

  assign accept_p0 = |gnt_p0;

  // One-hot grant mux; all fields stay zero when nobody is granted.
  always_comb begin
    sel_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_p0[i]) begin
        sel_p0.op     = BitOpEn_t'(bus.iReqOp[i]);
        sel_p0.s1     = bus.iReqS1[i];
        sel_p0.s1sign = bus.iReqS1Sign[i];
        sel_p0.s2     = bus.iReqS2[i];
        sel_p0.s2sign = bus.iReqS2Sign[i];
        sel_p0.tag    = bus.iReqTag[i];
      end
    end
  end

  assign bad_op_p0 = !bitop_is_onehot(sel_p0.op);

  // An illegal op is still consumed, but the ALU is left idle for it.
  assign bus.oReqReady  = gnt_p0;
  assign bus.oAluOp     = (accept_p0 && !bad_op_p0) ? sel_p0.op : BitOpEn_t'('0);
  assign bus.oAluS1     = sel_p0.s1;
  assign bus.oAluS2     = sel_p0.s2;
  assign bus.oAluS1Sign = sel_p0.s1sign;
  assign bus.oAluS2Sign = sel_p0.s2sign;

  // ---- p1: one-entry response register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      rsp_result_p1 <= '0;
      rsp_id_p1     <= '0;
      rsp_tag_p1    <= '0;
      rsp_bad_p1    <= 1'b0;
    end else if (accept_p0) begin
      vld_p1        <= 1'b1;
      rsp_result_p1 <= bad_op_p0 ? '0 : bus.iAluResult;
      rsp_id_p1     <= gnt_idx_p0;
      rsp_tag_p1    <= sel_p0.tag;
      rsp_bad_p1    <= bad_op_p0;
    end else if (bus.iRspReady) begin
      vld_p1        <= 1'b0;
    end
  end

  assign bus.oRspValid  = vld_p1;
  assign bus.oRspResult = rsp_result_p1;
  assign bus.oRspId     = rsp_id_p1;
  assign bus.oRspTag    = rsp_tag_p1;
  assign bus.oRspBadOp  = rsp_bad_p1;

endmodule

// File: tb/tb_ex_alu_share_ctrl.sv
// tb_ex_alu_share_ctrl
//   Testbench for ex_alu_share_ctrl with NREQ=2, XLEN=32, TAGW=4. The bench
//   plays the shared ALU and the requesters/consumer, and compares the
//   controller against directed expectations and a cycle-level model.
module tb_ex_alu_share_ctrl;

  localparam int XLEN = 32;
  localparam int NREQ = 2;
  localparam int TAGW = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ex_alu_share_ctrl_if #(.XLEN(XLEN), .NREQ(NREQ), .TAGW(TAGW)) bus ();

  ex_alu_share_ctrl #(.XLEN(XLEN), .NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU function; op 0 or an illegal op yields a marker value.
  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic sa, input logic sb);
    logic signed [32:0] xa;
    logic signed [32:0] xb;
    xa = {sa, a};
    xb = {sb, b};
    case (op)
      5'b00001: return a & b;
      5'b00010: return a | b;
      5'b00100: return a ^ b;
      5'b01000: return a - b;
      5'b10000: return (xa < xb) ? 32'd1 : 32'd0;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // The shared ALU, driven by the controller.
  always_comb bus.iAluResult = alu_ref(bus.oAluOp, bus.oAluS1, bus.oAluS2,
                                       bus.oAluS1Sign, bus.oAluS2Sign);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iReqValid  = '0;
    bus.iReqOp     = '0;
    bus.iReqS1     = '0;
    bus.iReqS2     = '0;
    bus.iReqS1Sign = '0;
    bus.iReqS2Sign = '0;
    bus.iReqTag    = '0;
    bus.iRspReady  = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sa, input logic sb,
                         input logic [3:0] tag);
    bus.iReqOp[i]     = op;
    bus.iReqS1[i]     = a;
    bus.iReqS2[i]     = b;
    bus.iReqS1Sign[i] = sa;
    bus.iReqS2Sign[i] = sb;
    bus.iReqTag[i]    = tag;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    set_req(0, 5'b00001, 32'h1, 32'h1, 1'b0, 1'b0, 4'h1);
    set_req(1, 5'b00010, 32'h2, 32'h2, 1'b0, 1'b0, 4'h2);
    bus.iReqValid = 2'b11;
    tick();
    tick();
    n_cmp++;
    if (bus.oReqReady !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", bus.oReqReady);
    end
    n_cmp++;
    if (bus.oAluOp !== 5'b0) begin
      n_err++; $display("FAIL reset_aluop: got %b want 00000", bus.oAluOp);
    end
    n_cmp++;
    if (bus.oRspValid !== 1'b0 || bus.oRspResult !== 32'h0 || bus.oRspId !== 1'b0 ||
        bus.oRspTag !== 4'h0 || bus.oRspBadOp !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp: got v=%b r=%h id=%b tag=%h bad=%b want all 0",
                        bus.oRspValid, bus.oRspResult, bus.oRspId, bus.oRspTag, bus.oRspBadOp);
    end
    rst_n = 1'b1;
    bus.iReqValid = 2'b00;
    #1;
    n_cmp++;
    if (bus.oReqReady !== 2'b00) begin
      n_err++; $display("FAIL idle_ready: got %b want 00", bus.oReqReady);
    end
    bus.iReqValid = 2'b11;
    #1;
    n_cmp++;
    if (bus.oReqReady !== 2'b01) begin
      n_err++; $display("FAIL reset_ptr_grant: got %b want 01", bus.oReqReady);
    end
    bus.iReqValid = 2'b00;
    tick();
  endtask

  task automatic test_single_op();
    set_req(0, 5'b00001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 4'd3);
    bus.iReqValid = 2'b01;
    bus.iRspReady = 1'b1;
    #1;
    n_cmp++;
    if (bus.oReqReady !== 2'b01 || bus.oAluOp !== 5'b00001 || bus.oAluS1 !== 32'hF0F0_F0F0 ||
        bus.oAluS2 !== 32'hFF00_FF00) begin
      n_err++; $display("FAIL single_issue: got rdy=%b op=%b s1=%h s2=%h want 01 00001 f0f0f0f0 ff00ff00",
                        bus.oReqReady, bus.oAluOp, bus.oAluS1, bus.oAluS2);
    end
    tick();
    bus.iReqValid = 2'b00;
    n_cmp++;
    if (bus.oRspValid !== 1'b1 || bus.oRspResult !== 32'hF000_F000 || bus.oRspId !== 1'b0 ||
        bus.oRspTag !== 4'd3 || bus.oRspBadOp !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: got v=%b r=%h id=%b tag=%h bad=%b want 1 f000f000 0 3 0",
                        bus.oRspValid, bus.oRspResult, bus.oRspId, bus.oRspTag, bus.oRspBadOp);
    end
    tick();
    n_cmp++;
    if (bus.oRspValid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: got v=%b want 0", bus.oRspValid);
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    logic [3:0]  exp_t;
    pulse_reset();
    set_req(0, 5'b00010, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 4'd5);
    set_req(1, 5'b01000, 32'd100, 32'd1, 1'b0, 1'b0, 4'd6);
    bus.iReqValid = 2'b11;
    bus.iRspReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (c % 2 == 0) ? 32'h1234_5678 : 32'd99;
      exp_t = (c % 2 == 0) ? 4'd5 : 4'd6;
      #1;
      n_cmp++;
      if (bus.oReqReady !== exp_g) begin
        n_err++; $display("FAIL fair_grant[%0d]: got %b want %b", c, bus.oReqReady, exp_g);
      end
      tick();
      n_cmp++;
      if (bus.oRspValid !== 1'b1 || bus.oRspId !== 1'(c % 2) || bus.oRspResult !== exp_r ||
          bus.oRspTag !== exp_t) begin
        n_err++; $display("FAIL fair_rsp[%0d]: got v=%b id=%b r=%h tag=%h want 1 %0d %h %h",
                          c, bus.oRspValid, bus.oRspId, bus.oRspResult, bus.oRspTag,
                          c % 2, exp_r, exp_t);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.iRspReady = 1'b0;
    set_req(0, 5'b00100, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 1'b0, 4'd9);
    bus.iReqValid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.oReqReady !== 2'b00 || bus.oAluOp !== 5'b0) begin
        n_err++; $display("FAIL stall_issue[%0d]: got rdy=%b op=%b want 00 00000",
                          c, bus.oReqReady, bus.oAluOp);
      end
      tick();
      n_cmp++;
      if (bus.oRspValid !== 1'b1 || bus.oRspId !== 1'b1 || bus.oRspResult !== 32'd99 ||
          bus.oRspTag !== 4'd6) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%b id=%b r=%h tag=%h want 1 1 00000063 6",
                          c, bus.oRspValid, bus.oRspId, bus.oRspResult, bus.oRspTag);
      end
    end
    bus.iRspReady = 1'b1;
    #1;
    n_cmp++;
    if (bus.oReqReady !== 2'b01) begin
      n_err++; $display("FAIL drain_accept_grant: got %b want 01", bus.oReqReady);
    end
    tick();
    bus.iReqValid = 2'b00;
    n_cmp++;
    if (bus.oRspValid !== 1'b1 || bus.oRspId !== 1'b0 || bus.oRspResult !== 32'h5555_5555 ||
        bus.oRspTag !== 4'd9) begin
      n_err++; $display("FAIL drain_accept_rsp: got v=%b id=%b r=%h tag=%h want 1 0 55555555 9",
                        bus.oRspValid, bus.oRspId, bus.oRspResult, bus.oRspTag);
    end
    tick();
  endtask

  task automatic test_slt();
    set_req(0, 5'b10000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 4'd2);
    bus.iReqValid = 2'b01;
    bus.iRspReady = 1'b1;
    #1;
    n_cmp++;
    if (bus.oReqReady !== 2'b01 || bus.oAluOp !== 5'b10000 || bus.oAluS1Sign !== 1'b1 ||
        bus.oAluS2Sign !== 1'b0) begin
      n_err++; $display("FAIL slt_issue: got rdy=%b op=%b sg1=%b sg2=%b want 01 10000 1 0",
                        bus.oReqReady, bus.oAluOp, bus.oAluS1Sign, bus.oAluS2Sign);
    end
    tick();
    bus.iReqS1Sign[0] = 1'b0;
    n_cmp++;
    if (bus.oRspValid !== 1'b1 || bus.oRspResult !== 32'd1 || bus.oRspId !== 1'b0) begin
      n_err++; $display("FAIL slt_signed: got v=%b r=%h id=%b want 1 00000001 0",
                        bus.oRspValid, bus.oRspResult, bus.oRspId);
    end
    tick();
    bus.iReqValid = 2'b00;
    n_cmp++;
    if (bus.oRspValid !== 1'b1 || bus.oRspResult !== 32'd0) begin
      n_err++; $display("FAIL slt_unsigned: got v=%b r=%h want 1 00000000",
                        bus.oRspValid, bus.oRspResult);
    end
    tick();
  endtask

  task automatic test_badop_reset();
    set_req(1, 5'b00011, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 1'b0, 4'd7);
    bus.iReqValid = 2'b10;
    bus.iRspReady = 1'b1;
    #1;
    n_cmp++;
    if (bus.oReqReady !== 2'b10 || bus.oAluOp !== 5'b0) begin
      n_err++; $display("FAIL badop_issue: got rdy=%b op=%b want 10 00000",
                        bus.oReqReady, bus.oAluOp);
    end
    tick();
    bus.iReqValid = 2'b00;
    bus.iRspReady = 1'b0;
    n_cmp++;
    if (bus.oRspValid !== 1'b1 || bus.oRspBadOp !== 1'b1 || bus.oRspResult !== 32'h0 ||
        bus.oRspId !== 1'b1 || bus.oRspTag !== 4'd7) begin
      n_err++; $display("FAIL badop_rsp: got v=%b bad=%b r=%h id=%b tag=%h want 1 1 0 1 7",
                        bus.oRspValid, bus.oRspBadOp, bus.oRspResult, bus.oRspId, bus.oRspTag);
    end
    rst_n = 1'b0;
    bus.iRspReady = 1'b1;
    bus.iReqValid = 2'b01;
    #1;
    n_cmp++;
    if (bus.oReqReady !== 2'b00) begin
      n_err++; $display("FAIL reset_no_grant: got %b want 00", bus.oReqReady);
    end
    tick();
    n_cmp++;
    if (bus.oRspValid !== 1'b0 || bus.oRspBadOp !== 1'b0 || bus.oRspResult !== 32'h0 ||
        bus.oRspTag !== 4'h0) begin
      n_err++; $display("FAIL reset_discard: got v=%b bad=%b r=%h tag=%h want 0 0 0 0",
                        bus.oRspValid, bus.oRspBadOp, bus.oRspResult, bus.oRspTag);
    end
    rst_n = 1'b1;
    bus.iReqValid = 2'b00;
    tick();
  endtask

  task automatic test_random(input int cycles);
    int          ptr;
    int          g;
    int          idx;
    logic        mv;
    logic [31:0] mres;
    int          mid;
    logic [3:0]  mtag;
    logic        mbad;
    logic        free;
    logic [1:0]  exp_g;
    logic [4:0]  exp_op;
    logic [4:0]  op;
    clear_inputs();
    pulse_reset();
    ptr = 0; mv = 1'b0; mres = '0; mid = 0; mtag = '0; mbad = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < NREQ; i++) begin
        bus.iReqValid[i] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 9) < 8) op = 5'(1 << $urandom_range(0, 4));
        else op = 5'($urandom_range(0, 31));
        set_req(i, op, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      bus.iRspReady = ($urandom_range(0, 9) < 7);
      #1;
      g = -1;
      free = !mv || bus.iRspReady;
      if (rst_n && free) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr + k) % NREQ;
          if (g < 0 && bus.iReqValid[idx]) g = idx;
        end
      end
      exp_g  = (g >= 0) ? 2'(1 << g) : 2'b00;
      exp_op = (g >= 0 && $countones(bus.iReqOp[g]) == 1) ? bus.iReqOp[g] : 5'b0;
      n_cmp++;
      if (bus.oRspValid !== mv || bus.oRspResult !== mres || bus.oRspId !== 1'(mid) ||
          bus.oRspTag !== mtag || bus.oRspBadOp !== mbad) begin
        n_err++; $display("FAIL rand_rsp[%0d]: got v=%b r=%h id=%b tag=%h bad=%b want %b %h %0d %h %b",
                          c, bus.oRspValid, bus.oRspResult, bus.oRspId, bus.oRspTag, bus.oRspBadOp,
                          mv, mres, mid, mtag, mbad);
      end
      n_cmp++;
      if (bus.oReqReady !== exp_g) begin
        n_err++; $display("FAIL rand_grant[%0d]: got %b want %b", c, bus.oReqReady, exp_g);
      end
      n_cmp++;
      if (bus.oAluOp !== exp_op) begin
        n_err++; $display("FAIL rand_aluop[%0d]: got %b want %b", c, bus.oAluOp, exp_op);
      end
      if (!rst_n) begin
        mv = 1'b0; mres = '0; mid = 0; mtag = '0; mbad = 1'b0; ptr = 0;
      end else if (g >= 0) begin
        mv   = 1'b1;
        mbad = ($countones(bus.iReqOp[g]) != 1);
        mres = mbad ? 32'h0 : alu_ref(bus.iReqOp[g], bus.iReqS1[g], bus.iReqS2[g],
                                      bus.iReqS1Sign[g], bus.iReqS2Sign[g]);
        mid  = g;
        mtag = bus.iReqTag[g];
        ptr  = (g + 1) % NREQ;
      end else if (bus.iRspReady) begin
        mv = 1'b0;
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_op();
    test_fairness();
    test_backpressure();
    test_slt();
    test_badop_reset();
    test_random(500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
